// File: rtl/vga_timing_gen_pkg.sv
// Shared raster geometry for the VGA timing generator and its consumers.
// Default values describe 640x480 @ 60 Hz with a 25.175 MHz pixel clock.
package vga_timing_gen_pkg;

    // Raster counters are 10 bits wide, so an axis may be at most 1024 clocks/lines long.
    localparam int unsigned CNT_W   = 10;
    localparam int unsigned CNT_MAX = 1 << CNT_W;

    typedef logic [CNT_W-1:0] cnt_t;

    // Horizontal geometry, in pixel clocks.
    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;

    // Vertical geometry, in lines.
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;

    // Asserted level of the sync outputs (0 = active-low).
    localparam bit SYNC_ACTIVE = 1'b0;

    function automatic int unsigned axis_total(input int unsigned visible,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
        return visible + front + sync + back;
    endfunction

    localparam int unsigned H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: a wrapping counter plus registered blank/sync/last flags.
// Flags are derived from the next count value, so they always describe the
// count presented in the same cycle.
module vga_timing_gen_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned Visible    = H_VISIBLE,
    parameter int unsigned Front      = H_FRONT,
    parameter int unsigned Sync       = H_SYNC,
    parameter int unsigned Back       = H_BACK,
    parameter bit          SyncActive = SYNC_ACTIVE
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic step_i,
    output cnt_t count_o,
    output logic blank_o,
    output logic sync_o,
    output logic last_o,
    output logic last_next_o
);

    localparam int unsigned Total     = axis_total(Visible, Front, Sync, Back);
    localparam int unsigned SyncStart = Visible + Front;
    localparam int unsigned SyncEnd   = SyncStart + Sync;

    if (Total > CNT_MAX) begin : g_total_check
        $error("vga_timing_gen: axis total %0d does not fit a %0d-bit counter", Total, CNT_W);
    end

    cnt_t        count_q, count_d;
    logic        blank_q, blank_d;
    logic        sync_q, sync_d;
    logic        last_q, last_d;
    logic [31:0] count_ext;

    // Next count and the flags that will accompany it.
    always_comb begin
        count_d = count_q;
        if (step_i) begin
            count_d = last_q ? '0 : count_q + 1'b1;
        end
        count_ext = 32'(count_d);
        blank_d   = (count_ext >= Visible);
        sync_d    = (count_ext >= SyncStart && count_ext < SyncEnd) ? SyncActive : !SyncActive;
        last_d    = (count_ext == Total - 1);
    end

    // Counter and flag registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
            blank_q <= 1'b0;
            sync_q  <= !SyncActive;
            last_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            blank_q <= blank_d;
            sync_q  <= sync_d;
            last_q  <= last_d;
        end
    end

    assign count_o     = count_q;
    assign blank_o     = blank_q;
    assign sync_o      = sync_q;
    assign last_o      = last_q;
    // Lets the parent register flags that combine both axes without a cycle of lag.
    assign last_next_o = last_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: column/row counters, blanking flags, line/frame
// end pulses and sync outputs, all registered.
// Optional macro VGA_FRAME_COUNTER_EN adds an 8-bit frame counter output o_Frame.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned p_H_VISIBLE   = H_VISIBLE,
    parameter int unsigned p_H_FRONT     = H_FRONT,
    parameter int unsigned p_H_SYNC      = H_SYNC,
    parameter int unsigned p_H_BACK      = H_BACK,
    parameter int unsigned p_V_VISIBLE   = V_VISIBLE,
    parameter int unsigned p_V_FRONT     = V_FRONT,
    parameter int unsigned p_V_SYNC      = V_SYNC,
    parameter int unsigned p_V_BACK      = V_BACK,
    parameter bit          p_SYNC_ACTIVE = SYNC_ACTIVE
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    output logic [CNT_W-1:0] o_Col,
    output logic [CNT_W-1:0] o_Row,
    output logic             o_HBlank,
    output logic             o_VBlank,
    output logic             o_HReset,
    output logic             o_VReset,
    output logic             o_HSync,
    output logic             o_VSync
`ifdef VGA_FRAME_COUNTER_EN
    ,
    output logic [7:0]       o_Frame
`endif
);

    cnt_t h_count, v_count;
    logic h_blank, v_blank;
    logic h_sync, v_sync;
    logic h_last, v_last;
    logic h_last_next, v_last_next;
    logic vreset_q, vreset_d;
    logic unused_v_last;

    vga_timing_gen_axis_counter #(
        .Visible   (p_H_VISIBLE),
        .Front     (p_H_FRONT),
        .Sync      (p_H_SYNC),
        .Back      (p_H_BACK),
        .SyncActive(p_SYNC_ACTIVE)
    ) u_h_axis (
        .clk_i      (i_Clk),
        .rst_ni     (i_Rst_n),
        .step_i     (1'b1),
        .count_o    (h_count),
        .blank_o    (h_blank),
        .sync_o     (h_sync),
        .last_o     (h_last),
        .last_next_o(h_last_next)
    );

    // Rows step on the last clock of each line.
    vga_timing_gen_axis_counter #(
        .Visible   (p_V_VISIBLE),
        .Front     (p_V_FRONT),
        .Sync      (p_V_SYNC),
        .Back      (p_V_BACK),
        .SyncActive(p_SYNC_ACTIVE)
    ) u_v_axis (
        .clk_i      (i_Clk),
        .rst_ni     (i_Rst_n),
        .step_i     (h_last),
        .count_o    (v_count),
        .blank_o    (v_blank),
        .sync_o     (v_sync),
        .last_o     (v_last),
        .last_next_o(v_last_next)
    );

    // Frame-end pulse uses the registered form instead, kept from both axes' next state.
    assign unused_v_last = v_last;

    // Frame end is the next position being the last column of the last row.
    always_comb begin
        vreset_d = h_last_next & v_last_next;
    end

    // Frame-end pulse register.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            vreset_q <= 1'b0;
        end else begin
            vreset_q <= vreset_d;
        end
    end

`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] frame_q, frame_d;

    // Frame count advances as the row wraps back to 0, i.e. the clock after o_VReset.
    always_comb begin
        frame_d = vreset_q ? frame_q + 8'd1 : frame_q;
    end

    // Frame counter register, wraps naturally at 8 bits.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            frame_q <= 8'd0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign o_Frame = frame_q;
`endif

    assign o_Col    = h_count;
    assign o_Row    = v_count;
    assign o_HBlank = h_blank;
    assign o_VBlank = v_blank;
    assign o_HReset = h_last;
    assign o_VReset = vreset_q;
    assign o_HSync  = h_sync;
    assign o_VSync  = v_sync;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-geometry instance and a tiny-geometry,
// active-high-sync instance share clock and reset. A cycle model pushes the
// expected output vector of each instance into a queue every clock; the queue is
// popped and compared once the DUT has produced that cycle's outputs.
module tb_vga_timing_gen;

`ifdef VGA_FRAME_COUNTER_EN
    localparam bit FRAME_EN = 1'b1;
`else
    localparam bit FRAME_EN = 1'b0;
`endif

    // Default geometry (640x480).
    localparam int DHV = 640, DHF = 16, DHS = 96, DHB = 48;
    localparam int DVV = 480, DVF = 10, DVS = 2, DVB = 33;
    localparam int DHT = DHV + DHF + DHS + DHB;
    localparam int DVT = DVV + DVF + DVS + DVB;
    // Tiny geometry so whole frames run quickly: 12 clocks x 8 lines.
    localparam int SHV = 8, SHF = 1, SHS = 2, SHB = 1;
    localparam int SVV = 4, SVF = 1, SVS = 2, SVB = 1;
    localparam int SHT = SHV + SHF + SHS + SHB;
    localparam int SVT = SVV + SVF + SVS + SVB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] d_col, d_row, s_col, s_row;
    logic       d_hb, d_vb, d_hr, d_vr, d_hs, d_vs;
    logic       s_hb, s_vb, s_hr, s_vr, s_hs, s_vs;
    logic [7:0] d_frame, s_frame;

    vga_timing_gen dut_d (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .o_Col   (d_col),
        .o_Row   (d_row),
        .o_HBlank(d_hb),
        .o_VBlank(d_vb),
        .o_HReset(d_hr),
        .o_VReset(d_vr),
        .o_HSync (d_hs),
        .o_VSync (d_vs)
`ifdef VGA_FRAME_COUNTER_EN
        ,
        .o_Frame (d_frame)
`endif
    );

    vga_timing_gen #(
        .p_H_VISIBLE  (SHV),
        .p_H_FRONT    (SHF),
        .p_H_SYNC     (SHS),
        .p_H_BACK     (SHB),
        .p_V_VISIBLE  (SVV),
        .p_V_FRONT    (SVF),
        .p_V_SYNC     (SVS),
        .p_V_BACK     (SVB),
        .p_SYNC_ACTIVE(1'b1)
    ) dut_s (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .o_Col   (s_col),
        .o_Row   (s_row),
        .o_HBlank(s_hb),
        .o_VBlank(s_vb),
        .o_HReset(s_hr),
        .o_VReset(s_vr),
        .o_HSync (s_hs),
        .o_VSync (s_vs)
`ifdef VGA_FRAME_COUNTER_EN
        ,
        .o_Frame (s_frame)
`endif
    );

`ifndef VGA_FRAME_COUNTER_EN
    assign d_frame = 8'h00;
    assign s_frame = 8'h00;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [33:0] q_d[$];
    logic [33:0] q_s[$];

    // Model state: position expected after the next clock edge.
    int mcol_d = 0, mrow_d = 0, mfr_d = 0;
    int mcol_s = 0, mrow_s = 0, mfr_s = 0;

    function automatic logic [33:0] model_out(input int col, input int row, input int fr,
                                              input int hv, input int hf, input int hs,
                                              input int hb, input int vv, input int vf,
                                              input int vs, input int vb, input bit act);
        int   ht = hv + hf + hs + hb;
        int   vt = vv + vf + vs + vb;
        logic hbk = (col >= hv);
        logic vbk = (row >= vv);
        logic hr  = (col == ht - 1);
        logic vr  = hr && (row == vt - 1);
        logic hsy = (col >= hv + hf && col < hv + hf + hs) ? act : !act;
        logic vsy = (row >= vv + vf && row < vv + vf + vs) ? act : !act;
        int   f   = FRAME_EN ? fr : 0;
        return {10'(col), 10'(row), hbk, vbk, hr, vr, hsy, vsy, 8'(f)};
    endfunction

    task automatic adv(input logic rst_v, input int ht, input int vt,
                       inout int col, inout int row, inout int fr);
        if (!rst_v) begin
            col = 0;
            row = 0;
            fr  = 0;
        end else if (col == ht - 1) begin
            col = 0;
            if (row == vt - 1) begin
                row = 0;
                fr  = (fr + 1) % 256;
            end else begin
                row++;
            end
        end else begin
            col++;
        end
    endtask

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive reset for one clock, queue the model's expectation, then compare.
    task automatic tick(input logic rst_v);
        rst_n = rst_v;
        adv(rst_v, DHT, DVT, mcol_d, mrow_d, mfr_d);
        q_d.push_back(model_out(mcol_d, mrow_d, mfr_d, DHV, DHF, DHS, DHB,
                                DVV, DVF, DVS, DVB, 1'b0));
        adv(rst_v, SHT, SVT, mcol_s, mrow_s, mfr_s);
        q_s.push_back(model_out(mcol_s, mrow_s, mfr_s, SHV, SHF, SHS, SHB,
                                SVV, SVF, SVS, SVB, 1'b1));
        @(posedge clk);
        #1;
        chk("cycle_default", {d_col, d_row, d_hb, d_vb, d_hr, d_vr, d_hs, d_vs, d_frame},
            q_d.pop_front());
        chk("cycle_small", {s_col, s_row, s_hb, s_vb, s_hr, s_vr, s_hs, s_vs, s_frame},
            q_s.pop_front());
        if (n_fail >= 50) begin
            $display("FAIL abort after %0d failed comparisons", n_fail);
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $finish;
        end
    endtask

    int   hs_low, hb_rise_col, hr_cnt, hr_col;
    logic prev_hb;
    int   s_hr_cnt, s_vr_cnt, s_vr_coinc, s_vis, s_vs_cnt, s_hs_cnt;
    int   vr_total;
    bit   found;

    task automatic sample_small();
        if (s_hr) s_hr_cnt++;
        if (s_vr) s_vr_cnt++;
        if (s_vr && s_hr && s_hb && s_vb) s_vr_coinc++;
        if (!s_hb && !s_vb) s_vis++;
        if (s_vs) s_vs_cnt++;
        if (s_hs) s_hs_cnt++;
    endtask

    initial begin
        // Reset held for 5 clocks: every cycle shows reset values.
        repeat (5) tick(1'b0);
        chk("reset_default_syncs_idle", 34'({d_hs, d_vs}), 34'(2'b11));
        chk("reset_default_pos", 34'({d_col, d_row, d_hb, d_vb, d_hr, d_vr}), 34'(0));

        // One default line: (0,0) is showing, 799 more clocks reach column 799.
        hs_low      = 0;
        hb_rise_col = -1;
        hr_cnt      = 0;
        hr_col      = -1;
        prev_hb     = d_hb;
        for (int i = 0; i < DHT - 1; i++) begin
            tick(1'b1);
            if (!d_hs) hs_low++;
            if (d_hb && !prev_hb) hb_rise_col = int'(d_col);
            prev_hb = d_hb;
            if (d_hr) begin
                hr_cnt++;
                hr_col = int'(d_col);
            end
        end
        chk("line_hsync_low_clocks", 34'(hs_low), 34'(96));
        chk("line_hblank_rise_col", 34'(hb_rise_col), 34'(640));
        chk("line_hreset_count", 34'(hr_cnt), 34'(1));
        chk("line_hreset_col", 34'(hr_col), 34'(799));
        tick(1'b1);
        chk("line_next_row", 34'({d_col, d_row}), 34'({10'd0, 10'd1}));

        // Mid-frame reset on the small raster while both syncs are asserted.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick(1'b1);
            if (s_col == 10'd9 && s_row == 10'd5) found = 1'b1;
        end
        chk("midrst_reach_9_5", 34'(found), 34'(1));
        chk("midrst_syncs_active", 34'({s_hs, s_vs}), 34'(2'b11));
        tick(1'b0);
        chk("midrst_small_cleared", 34'({s_col, s_row, s_hb, s_vb, s_hr, s_vr, s_hs, s_vs}),
            34'(0));
        chk("midrst_default_cleared", 34'({d_col, d_row, d_hr, d_vr, d_hs, d_vs}),
            34'(2'b11));

        // Two small frames from restart: the reset cycle plus 191 clocks.
        s_hr_cnt = 0; s_vr_cnt = 0; s_vr_coinc = 0; s_vis = 0; s_vs_cnt = 0; s_hs_cnt = 0;
        sample_small();
        for (int i = 0; i < 2 * SHT * SVT - 1; i++) begin
            tick(1'b1);
            sample_small();
        end
        chk("frames_hreset_pulses", 34'(s_hr_cnt), 34'(2 * SVT));
        chk("frames_vreset_pulses", 34'(s_vr_cnt), 34'(2));
        chk("frames_vreset_coincident", 34'(s_vr_coinc), 34'(2));
        chk("frames_visible_pixels", 34'(s_vis), 34'(2 * SHV * SVV));
        chk("frames_vsync_clocks", 34'(s_vs_cnt), 34'(2 * SVS * SHT));
        chk("frames_hsync_clocks", 34'(s_hs_cnt), 34'(2 * SVT * SHS));
        tick(1'b1);
        chk("frames_wrap_to_origin", 34'({s_col, s_row}), 34'(0));

        // Run to the 257th frame end after restart; the frame count wraps through 255.
        vr_total = 2;
        found    = 1'b0;
        for (int i = 0; i < 30000 && !found; i++) begin
            tick(1'b1);
            if (s_vr) begin
                vr_total++;
                if (vr_total == 257) found = 1'b1;
            end
        end
        chk("frame257_reached", 34'(found), 34'(1));
`ifdef VGA_FRAME_COUNTER_EN
        chk("frame_before_257th_step", 34'(s_frame), 34'(0));
`endif
        tick(1'b1);
`ifdef VGA_FRAME_COUNTER_EN
        chk("frame_after_wrap", 34'(s_frame), 34'(1));
`endif
        chk("frame257_origin", 34'({s_col, s_row}), 34'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
